vigna_mem_arbiter: RTL and testbench

//  Two-master, one-slave arbiter that shares one memory port between the vigna

---
 rtl/vigna_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_vigna_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vigna_mem_arbiter.sv
// vigna_mem_arbiter
//   Shares one memory port between the vigna instruction-fetch port (i_*) and
//   its data load/store port (d_*). Only one request is in flight at a time.
//   Read data is routed back to whichever port owns the transaction. A
//   transaction that never sees m_ready is aborted: the owner gets ERR_DATA
//   and an err pulse.
//
// Parameters
//   FIXED_D_PRIO  0: round-robin on contention, 1: data port always wins
//   TIMEOUT       max BUSY cycles spent waiting for m_ready (0 = never abort, < 256)
//   ERR_DATA      read data handed to the owner on timeout
//
// Ports
//   clk, resetn         clock (rising edge), synchronous active-low reset
//   i_valid/i_addr      fetch request, held until i_ready
//   i_ready/i_rdata     fetch completion pulse and data (data held afterwards)
//   d_valid/d_addr/
//   d_wdata/d_wstrb     data request (wstrb == 0 means read), held until d_ready
//   d_ready/d_rdata     data completion pulse and data (data held afterwards)
//   m_valid/m_addr/
//   m_wdata/m_wstrb     registered slave request
//   m_ready/m_rdata     slave completion; m_ready may be a pulse or level
//   err                 timeout pulse, coincident with the owner's ready
module vigna_mem_arbiter #(
    parameter bit          FIXED_D_PRIO = 1'b0,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,

    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,

    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic       OWN_I       = 1'b0;
    localparam logic       OWN_D       = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q,      state_d;
    logic        owner_q,      owner_d;
    logic        last_owner_q, last_owner_d;
    logic        err_pend_q,   err_pend_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic [31:0] rdata_buf_q,  rdata_buf_d;

    logic        m_valid_q,    m_valid_d;
    logic [31:0] m_addr_q,     m_addr_d;
    logic [31:0] m_wdata_q,    m_wdata_d;
    logic [3:0]  m_wstrb_q,    m_wstrb_d;
    logic        i_ready_q,    i_ready_d;
    logic        d_ready_q,    d_ready_d;
    logic [31:0] i_rdata_q,    i_rdata_d;
    logic [31:0] d_rdata_q,    d_rdata_d;
    logic        err_q,        err_d;

    logic        pick_d;
    logic [7:0]  cnt_inc;
    logic        timed_out;

    // Arbitration is evaluated only in IDLE. The owner's own valid is
    // therefore never looked at during RECOVER, while the other port's
    // request simply waits and is seen once IDLE is reached.
    always_comb begin
        if (FIXED_D_PRIO) begin
            pick_d = d_valid;
        end else if (i_valid && d_valid) begin
            // Tie: hand the grant to whichever port did not go last.
            pick_d = (last_owner_q == OWN_I);
        end else begin
            pick_d = d_valid;
        end
    end

    // The wait counter saturates, so the wrap of cnt_inc at 255 never reaches
    // wait_cnt_q; a nonzero TIMEOUT below 256 is always hit before that.
    assign cnt_inc   = wait_cnt_q + 8'd1;
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_pend_d   = err_pend_q;
        wait_cnt_d   = wait_cnt_q;
        rdata_buf_d  = rdata_buf_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid || d_valid) begin
                    owner_d    = pick_d ? OWN_D : OWN_I;
                    m_valid_d  = 1'b1;
                    m_addr_d   = pick_d ? d_addr  : i_addr;
                    m_wdata_d  = pick_d ? d_wdata : 32'd0;
                    m_wstrb_d  = pick_d ? d_wstrb : 4'd0;
                    wait_cnt_d = 8'd0;
                    err_pend_d = 1'b0;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (m_ready) begin
                    rdata_buf_d = m_rdata;
                    m_valid_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : cnt_inc;
                    if (timed_out) begin
                        rdata_buf_d = ERR_DATA;
                        err_pend_d  = 1'b1;
                        m_valid_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (owner_q == OWN_D) begin
                    d_ready_d = 1'b1;
                    d_rdata_d = rdata_buf_q;
                end else begin
                    i_ready_d = 1'b1;
                    i_rdata_d = rdata_buf_q;
                end
                err_d        = err_pend_q;
                last_owner_d = owner_q;
                state_d      = ST_RECOVER;
            end

            ST_RECOVER: begin
                // A slave holding m_ready as a level must release it before
                // the next grant, otherwise that grant would complete at once.
                if (!m_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            err_pend_q   <= 1'b0;
            wait_cnt_q   <= 8'd0;
            rdata_buf_q  <= 32'd0;
            m_valid_q    <= 1'b0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            m_wstrb_q    <= 4'd0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_pend_q   <= err_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            rdata_buf_q  <= rdata_buf_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_ready = i_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_ready = d_ready_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_vigna_mem_arbiter.sv
// Testbench for vigna_mem_arbiter: a round-robin instance driven by a table of
// transactions, plus hand-written sequences for level m_ready, reset during a
// transaction and a fixed-data-priority instance.
module tb_vigna_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_valid, d_valid;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        m_ready, f_m_ready;
    logic [31:0] m_rdata, f_m_rdata;

    logic        i_ready, d_ready, m_valid, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    logic        f_i_ready, f_d_ready, f_m_valid, f_err;
    logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata;
    logic [3:0]  f_m_wstrb;

    int n_checks = 0;
    int n_err    = 0;

    vigna_mem_arbiter #(.FIXED_D_PRIO(1'b0), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
    );

    vigna_mem_arbiter #(.FIXED_D_PRIO(1'b1), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut_f (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(f_i_ready), .i_rdata(f_i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(f_d_ready), .d_rdata(f_d_rdata),
        .m_valid(f_m_valid), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
        .m_ready(f_m_ready), .m_rdata(f_m_rdata), .err(f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        dv;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        int          lat;        // cycles before slave pulses m_ready; -1 = never
        logic [31:0] srd;
        logic        early;      // owner drops valid right after the grant
        logic        exp_own;    // 0 = fetch port, 1 = data port
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;    // cycles from m_valid seen to ready seen
    } vec_t;

    vec_t vecs[9];

    logic [31:0] mdl_i_rdata, mdl_d_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int   c;
        logic done;
        logic stable_bad;
        i_valid = v.iv;  d_valid = v.dv;
        i_addr  = v.ia;  d_addr  = v.da;
        d_wdata = v.dw;  d_wstrb = v.ds;
        c = 0;
        while (!m_valid && c < 10) begin
            tick();
            c++;
        end
        check($sformatf("v%0d_grant", k), 32'(m_valid), 32'd1);
        check($sformatf("v%0d_m_addr", k), m_addr, v.exp_addr);
        check($sformatf("v%0d_m_wdata", k), m_wdata, v.exp_wdata);
        check($sformatf("v%0d_m_wstrb", k), 32'(m_wstrb), 32'(v.exp_wstrb));
        if (v.early) begin
            if (v.exp_own) d_valid = 1'b0;
            else           i_valid = 1'b0;
        end
        c = 0;
        done = 1'b0;
        stable_bad = 1'b0;
        while (!done && c < 40) begin
            if (c == v.lat) begin
                m_ready = 1'b1;
                m_rdata = v.srd;
            end
            tick();
            c++;
            m_ready = 1'b0;
            m_rdata = 32'hBAD0BAD0;
            if (i_ready || d_ready) done = 1'b1;
            else if (m_valid && (m_addr !== v.exp_addr || m_wdata !== v.exp_wdata ||
                                 m_wstrb !== v.exp_wstrb)) stable_bad = 1'b1;
        end
        check($sformatf("v%0d_stable", k), 32'(stable_bad), 32'd0);
        check($sformatf("v%0d_ready_cycle", k), 32'(c), 32'(v.exp_cyc));
        check($sformatf("v%0d_i_ready", k), 32'(i_ready), 32'(!v.exp_own));
        check($sformatf("v%0d_d_ready", k), 32'(d_ready), 32'(v.exp_own));
        check($sformatf("v%0d_err", k), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_m_valid_resp", k), 32'(m_valid), 32'd0);
        if (v.exp_own) mdl_d_rdata = v.exp_rdata;
        else           mdl_i_rdata = v.exp_rdata;
        check($sformatf("v%0d_i_rdata", k), i_rdata, mdl_i_rdata);
        check($sformatf("v%0d_d_rdata", k), d_rdata, mdl_d_rdata);
        i_valid = 1'b0;
        d_valid = 1'b0;
        tick();
        check($sformatf("v%0d_pulse_end", k), {29'd0, i_ready, d_ready, err}, 32'd0);
        tick();
        check($sformatf("v%0d_idle", k), 32'(m_valid), 32'd0);
    endtask

    initial begin
        int   c;
        logic bad;

        vecs[0] = '{1'b1, 1'b1, 32'h200, 32'h0, 32'h0,        4'h0, 0,  32'h00000013, 1'b0,
                    1'b0, 32'h200, 32'h0,        4'h0, 32'h00000013, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h0, 32'h0,        4'h0, 1,  32'h3F800000, 1'b0,
                    1'b1, 32'h0,   32'h0,        4'h0, 32'h3F800000, 1'b0, 3};
        vecs[2] = '{1'b1, 1'b1, 32'h204, 32'h8, 32'hCAFEF00D, 4'h3, 0,  32'h00000093, 1'b0,
                    1'b0, 32'h204, 32'h0,        4'h0, 32'h00000093, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 32'h204, 32'h8, 32'hCAFEF00D, 4'h0, 0,  32'h40490FDB, 1'b0,
                    1'b1, 32'h8,   32'hCAFEF00D, 4'h0, 32'h40490FDB, 1'b0, 2};
        vecs[4] = '{1'b1, 1'b0, 32'h4,   32'h0, 32'h0,        4'h0, 2,  32'hFF800067, 1'b0,
                    1'b0, 32'h4,   32'h0,        4'h0, 32'hFF800067, 1'b0, 4};
        vecs[5] = '{1'b0, 1'b1, 32'h0,   32'h100, 32'h12345678, 4'hF, 3, 32'hA5A5A5A5, 1'b0,
                    1'b1, 32'h100, 32'h12345678, 4'hF, 32'hA5A5A5A5, 1'b0, 5};
        vecs[6] = '{1'b1, 1'b0, 32'h8,   32'h0, 32'h0,        4'h0, 1,  32'h11112222, 1'b1,
                    1'b0, 32'h8,   32'h0,        4'h0, 32'h11112222, 1'b0, 3};
        vecs[7] = '{1'b0, 1'b1, 32'h0,   32'h40, 32'h0,       4'h0, -1, 32'h0,        1'b0,
                    1'b1, 32'h40,  32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 17};
        vecs[8] = '{1'b1, 1'b0, 32'hC,   32'h0, 32'h0,        4'h0, 0,  32'h00000055, 1'b0,
                    1'b0, 32'hC,   32'h0,        4'h0, 32'h00000055, 1'b0, 2};

        resetn = 1'b0;
        i_valid = 1'b1; d_valid = 1'b1;
        i_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'h12345678; d_wstrb = 4'hF;
        m_ready = 1'b0; m_rdata = 32'h0; f_m_ready = 1'b0; f_m_rdata = 32'h0;
        mdl_i_rdata = 32'd0;
        mdl_d_rdata = 32'd0;

        // Reset held with both ports requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_ctrl_%0d", i), {28'd0, i_ready, d_ready, m_valid, err}, 32'd0);
        end
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_m_wstrb", 32'(m_wstrb), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_f_m_valid", 32'(f_m_valid), 32'd0);
        i_valid = 1'b0;
        d_valid = 1'b0;
        resetn = 1'b1;
        tick();

        foreach (vecs[k]) run_vec(k, vecs[k]);

        // Slave holds m_ready as a level: no new grant until it drops
        d_valid = 1'b1; d_addr = 32'h300; d_wstrb = 4'h0; d_wdata = 32'h0;
        c = 0;
        while (!m_valid && c < 10) begin tick(); c++; end
        check("hold_grant", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        m_rdata = 32'h00000077;
        c = 0;
        while (!d_ready && c < 10) begin tick(); c++; end
        check("hold_ready_cycle", 32'(c), 32'd2);
        check("hold_d_rdata", d_rdata, 32'h00000077);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_valid) bad = 1'b1;
        end
        check("hold_no_regrant", 32'(bad), 32'd0);
        m_ready = 1'b0;
        c = 0;
        while (!m_valid && c < 10) begin tick(); c++; end
        check("hold_regrant_cycle", 32'(c), 32'd2);
        m_ready = 1'b1;
        m_rdata = 32'h00000088;
        tick();
        m_ready = 1'b0;
        c = 1;
        while (!d_ready && c < 10) begin tick(); c++; end
        check("hold2_ready_cycle", 32'(c), 32'd2);
        check("hold2_d_rdata", d_rdata, 32'h00000088);
        d_valid = 1'b0;
        tick();
        tick();

        // Reset while BUSY abandons the transaction
        d_valid = 1'b1; d_addr = 32'h600;
        c = 0;
        while (!m_valid && c < 10) begin tick(); c++; end
        check("mrst_grant", 32'(m_valid), 32'd1);
        tick();
        tick();
        resetn = 1'b0;
        d_valid = 1'b0;
        m_ready = 1'b1;
        m_rdata = 32'h99999999;
        tick();
        check("mrst_m_valid", 32'(m_valid), 32'd0);
        check("mrst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        m_ready = 1'b0;
        resetn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i_ready || d_ready || m_valid || err) bad = 1'b1;
        end
        check("mrst_quiet", 32'(bad), 32'd0);
        check("mrst_d_rdata", d_rdata, 32'd0);

        // Fixed data priority: D wins two arbitrations in a row
        i_valid = 1'b1; d_valid = 1'b1;
        i_addr = 32'h400; d_addr = 32'h500; d_wstrb = 4'h0;
        c = 0;
        while (!f_m_valid && c < 10) begin tick(); c++; end
        check("fix1_m_addr", f_m_addr, 32'h500);
        f_m_ready = 1'b1;
        f_m_rdata = 32'h00000001;
        tick();
        f_m_ready = 1'b0;
        c = 0;
        while (!f_d_ready && c < 10) begin tick(); c++; end
        check("fix1_d_ready", 32'(f_d_ready), 32'd1);
        check("fix1_i_ready", 32'(f_i_ready), 32'd0);
        check("fix1_d_rdata", f_d_rdata, 32'h00000001);
        tick();
        c = 0;
        while (!f_m_valid && c < 10) begin tick(); c++; end
        check("fix2_m_addr", f_m_addr, 32'h500);
        f_m_ready = 1'b1;
        f_m_rdata = 32'h00000002;
        tick();
        f_m_ready = 1'b0;
        c = 0;
        while (!f_d_ready && c < 10) begin tick(); c++; end
        check("fix2_d_rdata", f_d_rdata, 32'h00000002);
        check("fix2_i_rdata", f_i_rdata, 32'd0);
        i_valid = 1'b0;
        d_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
